// File: rtl/mem_arb_if.sv
// Request/memory bundle between the two requesters, the memory and mem_arb.
// The master side is the environment; the slave side is the arbiter itself.
interface mem_arb_if #(
    parameter int AW = 9,
    parameter int DW = 16
);
    logic          req0, req1;
    logic [1:0]    cmd0, cmd1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [DW-1:0] rdata0, rdata1;
    logic          done0, done1;
    logic [1:0]    mem_cmd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    gnt;
    logic          busy;

    modport slave (
        input  req0, req1, cmd0, cmd1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output rdata0, rdata1, done0, done1, mem_cmd, mem_addr, mem_wdata, gnt, busy
    );

    modport master (
        output req0, req1, cmd0, cmd1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  rdata0, rdata1, done0, done1, mem_cmd, mem_addr, mem_wdata, gnt, busy
    );
endinterface

// File: rtl/mem_arb.sv
// Two-port round-robin memory arbiter: one transaction at a time through
// IDLE->ACCESS->CAPTURE->DONE, ties broken against the previous owner.
module mem_arb_port #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset)     q <= '0;
        else if (load) q <= d;
    end
endmodule

module mem_arb #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic     clk,
    input  logic     reset,
    mem_arb_if.slave bus
);
    localparam logic [1:0] CMD_RD   = 2'b11;
    localparam logic [1:0] CMD_WR   = 2'b01;
    localparam logic [1:0] CMD_NONE = 2'b00;

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

    typedef struct packed {
        logic [1:0]    cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    state_t          state;
    req_t [1:0]      port_req;
    req_t            lat;
    logic [1:0]      req_v;
    logic            win;
    logic            owner;
    logic            last_owner;
    logic [1:0]      mem_cmd_q;
    logic [1:0]      gnt_q;
    logic [1:0]      done_q;
    logic            busy_q;
    logic [1:0]      rd_load;
    logic [1:0][DW-1:0] rd_q;

    always_comb begin
        req_v             = {bus.req1, bus.req0};
        port_req[0].cmd   = bus.cmd0;
        port_req[0].addr  = bus.addr0;
        port_req[0].wdata = bus.wdata0;
        port_req[1].cmd   = bus.cmd1;
        port_req[1].addr  = bus.addr1;
        port_req[1].wdata = bus.wdata1;
    end

    // On a tie the port that did not win last time goes next.
    always_comb begin
        win = 1'b0;
        if (&req_v)        win = ~last_owner;
        else if (req_v[1]) win = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            owner      <= 1'b0;
            lat        <= '0;
            mem_cmd_q  <= CMD_NONE;
            gnt_q      <= 2'b00;
            done_q     <= 2'b00;
            busy_q     <= 1'b0;
        end else begin
            done_q <= 2'b00;
            case (state)
                IDLE: begin
                    if (|req_v) begin
                        owner      <= win;
                        last_owner <= win;
                        lat        <= port_req[win];
                        mem_cmd_q  <= (port_req[win].cmd == CMD_RD || port_req[win].cmd == CMD_WR)
                                      ? port_req[win].cmd : CMD_NONE;
                        gnt_q      <= 2'b01 << win;
                        busy_q     <= 1'b1;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_cmd_q <= CMD_NONE;
                    state     <= CAPTURE;
                end
                CAPTURE: begin
                    done_q[owner] <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    gnt_q  <= 2'b00;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read data is valid in CAPTURE, one cycle after the read command.
    for (genvar i = 0; i < 2; i++) begin : g_port
        assign rd_load[i] = (state == CAPTURE) && (owner == 1'(i)) && (lat.cmd == CMD_RD);
        mem_arb_port #(.DW(DW)) u_port (
            .clk   (clk),
            .reset (reset),
            .load  (rd_load[i]),
            .d     (bus.mem_rdata),
            .q     (rd_q[i])
        );
    end

    assign bus.rdata0    = rd_q[0];
    assign bus.rdata1    = rd_q[1];
    assign bus.done0     = done_q[0];
    assign bus.done1     = done_q[1];
    assign bus.mem_cmd   = mem_cmd_q;
    assign bus.mem_addr  = lat.addr;
    assign bus.mem_wdata = lat.wdata;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = busy_q;
endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter AW, default 9, memory address width in bits.
REQ-002 Parameter DW, default 16, memory data width in bits.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Ports req0, req1  input  1 each  access request from port 0 (CPU) and port 1 (loader).
REQ-006 Ports cmd0, cmd1  input  2 each  command: 2'b11 read, 2'b01 write, others no-op.
REQ-007 Ports addr0, addr1  input  AW each  word address.
REQ-008 Ports wdata0, wdata1  input  DW each  write data.
REQ-009 Ports rdata0, rdata1  output  DW each  registered read result per port.
REQ-010 Ports done0, done1  output  1 each  one-cycle completion pulse per port.
REQ-011 Port mem_cmd  output  2  memory command, same encoding as cmdN; 2'b00 = none.
REQ-012 Port mem_addr  output  AW  memory address.
REQ-013 Port mem_wdata  output  DW  memory write data.
REQ-014 Port mem_rdata  input  DW  memory read data, valid the cycle after mem_cmd=11.
REQ-015 Port gnt  output  2  one-hot current owner; 2'b00 when idle.
REQ-016 Port busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM SHALL have exactly four states: IDLE, ACCESS, CAPTURE, DONE; sequence IDLE->ACCESS->CAPTURE->DONE->IDLE, no skipping.
REQ-018 IDLE: neither req high -> stay IDLE; mem_cmd=00, gnt=00.
REQ-019 IDLE, one req high -> grant that port; both high -> grant the port not in last_owner register.
REQ-020 On leaving IDLE, winner's cmd, addr, wdata SHALL be latched; later changes on its inputs are ignored until DONE.
REQ-021 last_owner SHALL update to the winner on each grant; reset value = port 1 (port 0 wins the first tie).
REQ-022 ACCESS: mem_cmd = latched cmd if 11 or 01, else 00; mem_addr/mem_wdata = latched values.
REQ-023 Outside ACCESS: mem_cmd=00; mem_addr/mem_wdata hold the last latched values.
REQ-024 CAPTURE: for a read, owner's rdata register loads mem_rdata at the end of the cycle.
REQ-025 rdataN SHALL change only on a completed read by port N; writes and no-ops leave it unchanged.
REQ-026 DONE: doneN=1 for owner only, exactly one cycle; done of the other port 0.
REQ-027 Latency: req sampled high in IDLE at edge k -> ACCESS cycle k+1, CAPTURE k+2, DONE k+3, IDLE k+4.
REQ-028 req still high on return to IDLE SHALL be treated as a new request (re-arbitrated).
REQ-029 No-op commands SHALL complete through all four states with done pulse and no memory access.
REQ-030 gnt SHALL stay one-hot for the owner from ACCESS through DONE; never both bits set.
REQ-031 Requests arriving in non-IDLE states SHALL wait; no request is dropped while held high.
REQ-032 Strict alternation under continuous contention: grants 0,1,0,1,... with no starvation.

Reset
REQ-033 reset high at a clock edge -> state IDLE, last_owner=1, rdata0=rdata1=0, latched regs 0.
REQ-034 After reset: mem_cmd=00, mem_addr=0, mem_wdata=0, gnt=00, busy=0, done0=done1=0.
REQ-035 Reset mid-transaction SHALL abort it: no done pulse, no further memory command, rdata unchanged from reset value.
REQ-036 Reset overrides any simultaneous req; arbitration resumes the cycle after reset deasserts.

Verification
REQ-037 Port 0 write addr 9'h005 data 16'hBEEF -> mem_cmd=01, mem_addr=005, mem_wdata=BEEF for one cycle; done0 at k+3.
REQ-038 Then port 1 read addr 005 with memory model -> rdata1=BEEF, done1 pulse at k+3; rdata0 unchanged.
REQ-039 req0,req1 raised same cycle after reset, held -> grant order 0,1,0,1; no back-to-back same port.
REQ-040 Port 0 cmd=2'b10 -> mem_cmd stays 00 throughout, done0 pulses at k+3, rdata0 unchanged.
REQ-041 Assert reset during CAPTURE of a port 1 read -> next cycle IDLE, busy=0, no done1, rdata1=0.
REQ-042 Change addr0 to 9'h1FF during ACCESS -> mem_addr keeps the originally latched address.
